wb_cmd_master: RTL and testbench

//  Wishbone classic single-access initiator. Turns commands from a valid/ready stream into one

---
 rtl/wb_cmd_master_if.sv | 38 +++
 rtl/wb_cmd_master.sv | 128 ++++++++++++
 tb/tb_wb_cmd_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - Command/response streams and Wishbone master bus of wb_cmd_master
interface wb_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [3:0]  cmd_sel;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, busy_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_err, rsp_timeout, busy_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
   );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-access initiator fed by a cmd/rsp stream
// Define WBM_TIMEOUT_EN to abort bus cycles that see no ack/err within TIMEOUT cycles.
module wb_cmd_master #(
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   wb_cmd_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rsp_dat_q;
   logic        busy_q;
   logic        cyc_q;
   logic        stb_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic        bus_done;

   assign bus_done = bus.wb_ack_i | bus.wb_err_i;

`ifdef WBM_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic                 rsp_timeout_q;
   logic                 tmo_hit;

   // The count reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
   assign tmo_hit         = (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg  = (TIMEOUT < (1 << TIMEOUT_W));
   assign bus.rsp_timeout = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         busy_q      <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
`ifdef WBM_TIMEOUT_EN
         tmo_cnt       <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (bus.cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  cyc_q       <= 1'b1;
                  stb_q       <= 1'b1;
                  we_q        <= bus.cmd_we;
                  sel_q       <= bus.cmd_sel;
                  adr_q       <= bus.cmd_adr;
                  dat_q       <= bus.cmd_dat;
                  state       <= BUS;
`ifdef WBM_TIMEOUT_EN
                  tmo_cnt     <= '0;
`endif
               end
            end
            BUS: begin
               if (bus_done) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= bus.wb_err_i;
                  rsp_dat_q   <= (!we_q && bus.wb_ack_i && !bus.wb_err_i) ? bus.wb_dat_i : '0;
                  state       <= RESP;
`ifdef WBM_TIMEOUT_EN
                  rsp_timeout_q <= 1'b0;
               end else if (tmo_hit) begin
                  cyc_q         <= 1'b0;
                  stb_q         <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  rsp_dat_q     <= '0;
                  rsp_timeout_q <= 1'b1;
                  state         <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
`endif
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.busy_o    = busy_q;
   assign bus.wb_cyc_o  = cyc_q;
   assign bus.wb_stb_o  = stb_q;
   assign bus.wb_we_o   = we_q;
   assign bus.wb_sel_o  = sel_q;
   assign bus.wb_adr_o  = adr_q;
   assign bus.wb_dat_o  = dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - Randomized and directed bench for wb_cmd_master against a response model
module tb_wb_cmd_master;
   logic wb_clk_i;
   logic wb_rst_i;
   int   vectors;
   int   miscompares;

   wb_cmd_master_if bus();

   wb_cmd_master #(.TIMEOUT(16), .TIMEOUT_W(8)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus.master)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected response: {err, data}; an error always wins and zeroes the data, writes return 0.
   function automatic logic [32:0] model_rsp(input logic we, input logic ack, input logic err,
                                             input logic [31:0] rdata);
      if (err)       return {1'b1, 32'h0};
      if (we || !ack) return {1'b0, 32'h0};
      return {1'b0, rdata};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge wb_clk_i);
         n++;
      end
      check("cmd_ready_wait", {31'h0, bus.cmd_ready}, 32'h1);
   endtask

   task automatic issue_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat);
      wait_ready();
      bus.cmd_we    = we;
      bus.cmd_sel   = sel;
      bus.cmd_adr   = adr;
      bus.cmd_dat   = dat;
      bus.cmd_valid = 1'b1;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = ~we;
      bus.cmd_sel   = 4'($urandom);
      bus.cmd_adr   = $urandom;
      bus.cmd_dat   = $urandom;
   endtask

   // ack_cycle: which cycle of the bus access (1 = first cycle cyc is high) carries ack/err.
   task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_cycle, input logic do_ack,
                          input logic do_err, input logic [31:0] rdata, input int rsp_wait,
                          input logic extra_ack, input logic pend);
      logic [32:0] exp;
      exp = model_rsp(we, do_ack, do_err, rdata);
      issue_cmd(we, sel, adr, dat);
      for (int c = 1; c <= ack_cycle; c++) begin
         if (c > 1) @(negedge wb_clk_i);
         check("bus_hold", {22'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
               bus.cmd_ready, bus.rsp_valid, bus.busy_o},
               {22'h0, 1'b1, 1'b1, we, sel, 1'b0, 1'b0, 1'b1});
         check("bus_adr", bus.wb_adr_o, adr);
         check("bus_dat", bus.wb_dat_o, dat);
         if (c == ack_cycle) begin
            bus.wb_ack_i = do_ack;
            bus.wb_err_i = do_err;
            bus.wb_dat_i = rdata;
         end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_dat_i = $urandom;
         end
      end
      @(negedge wb_clk_i);
      bus.wb_ack_i = extra_ack;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = $urandom;
      check("rsp_enter", {28'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.rsp_timeout},
            32'h2);
      check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp[32]});
      check("rsp_dat", bus.rsp_dat, exp[31:0]);
      if (pend) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_adr   = $urandom;
      end
      for (int i = 0; i < rsp_wait; i++) begin
         @(negedge wb_clk_i);
         bus.wb_ack_i = 1'b0;
         check("bp_hold", {28'h0, bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.wb_cyc_o},
               {28'h0, 1'b1, exp[32], 1'b0, 1'b0});
         check("bp_dat", bus.rsp_dat, exp[31:0]);
      end
      bus.rsp_ready = 1'b1;
      @(negedge wb_clk_i);
      bus.rsp_ready = 1'b0;
      bus.wb_ack_i  = 1'b0;
      check("rsp_done", {29'h0, bus.rsp_valid, bus.cmd_ready, bus.wb_cyc_o}, 32'h2);
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      wb_rst_i      = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_adr   = '0;
      bus.cmd_dat   = '0;
      bus.rsp_ready = 1'b0;
      bus.wb_dat_i  = '0;
      bus.wb_ack_i  = 1'b0;
      bus.wb_err_i  = 1'b0;

      @(negedge wb_clk_i);
      check("reset_ctl", {21'h0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
            bus.busy_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 32'h0);
      check("reset_adr", bus.wb_adr_o, 32'h0);
      check("reset_dat", bus.wb_dat_o | bus.rsp_dat, 32'h0);
      wb_rst_i = 1'b0;
      check("ready_pre", {31'h0, bus.cmd_ready}, 32'h0);
      @(negedge wb_clk_i);
      check("ready_post", {31'h0, bus.cmd_ready}, 32'h1);

      run_txn(1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 2, 1'b1, 1'b0, 32'hA5A5A5A5, 0, 1'b1, 1'b0);
      run_txn(1'b0, 4'hF, 32'h04, 32'h0, 6, 1'b1, 1'b0, 32'h12345678, 0, 1'b0, 1'b0);
      run_txn(1'b0, 4'h3, 32'h08, 32'h0, 2, 1'b1, 1'b1, 32'hCAFEF00D, 0, 1'b1, 1'b0);
      run_txn(1'b0, 4'hF, 32'h0C, 32'h0, 2, 1'b1, 1'b0, 32'h0BADF00D, 10, 1'b0, 1'b1);
      run_txn(1'b1, 4'h1, 32'h10, 32'h55AA55AA, 1, 1'b0, 1'b1, 32'h0, 2, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         logic e;
         e = ($urandom_range(0, 3) == 0);
         run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom_range(1, 6),
                 e ? 1'($urandom) : 1'b1, e, $urandom, $urandom_range(0, 3),
                 1'($urandom), (i < 29) ? 1'($urandom) : 1'b0);
      end

`ifdef WBM_TIMEOUT_EN
      begin
         int n = 0;
         issue_cmd(1'b0, 4'hF, 32'h40, 32'h0);
         while (bus.wb_cyc_o && n < 40) begin
            n++;
            @(negedge wb_clk_i);
         end
         check("tmo_cycles", n, 32'd16);
         check("tmo_rsp", {29'h0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'h7);
         check("tmo_dat", bus.rsp_dat, 32'h0);
         bus.rsp_ready = 1'b1;
         @(negedge wb_clk_i);
         bus.rsp_ready = 1'b0;
      end
      run_txn(1'b0, 4'hF, 32'h44, 32'h0, 16, 1'b1, 1'b0, 32'h600DCAFE, 0, 1'b0, 1'b0);
      issue_cmd(1'b0, 4'hF, 32'h48, 32'h0);
      repeat (3) @(negedge wb_clk_i);
`else
      issue_cmd(1'b0, 4'hF, 32'h40, 32'h0);
      repeat (1000) @(negedge wb_clk_i);
      check("no_tmo", {29'h0, bus.wb_cyc_o, bus.rsp_valid, bus.rsp_timeout}, 32'h4);
`endif

      check("pre_rst_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
      #2 wb_rst_i = 1'b1;
      #1 check("async_rst", {28'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.busy_o},
               32'h0);
      @(negedge wb_clk_i);
      wb_rst_i     = 1'b0;
      bus.wb_ack_i = 1'b1;
      bus.wb_err_i = 1'b1;
      check("rst_rel_ready", {31'h0, bus.cmd_ready}, 32'h0);
      repeat (3) begin
         @(negedge wb_clk_i);
         check("spurious_ack", {29'h0, bus.cmd_ready, bus.wb_cyc_o, bus.rsp_valid}, 32'h4);
      end
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;

      issue_cmd(1'b0, 4'hF, 32'h50, 32'h0);
      bus.wb_ack_i = 1'b1;
      bus.wb_dat_i = 32'h13572468;
      @(negedge wb_clk_i);
      bus.wb_ack_i = 1'b0;
      check("pend_rsp", {31'h0, bus.rsp_valid}, 32'h1);
      #2 wb_rst_i = 1'b1;
      #1 check("rst_rsp_drop", {31'h0, bus.rsp_valid}, 32'h0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      run_txn(1'b0, 4'hC, 32'h54, 32'h0, 3, 1'b1, 1'b0, 32'h2468ACE0, 1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
